// File: rtl/seq_adder.sv
// seq_adder: multi-cycle adder that sums two W-bit operands CHUNK bits per
// clock, LSB chunk first, and publishes the full sum and carry in a one-cycle
// DONE state. The latched operands shift right each CALC cycle so the active
// chunk is always at the bottom, and the accumulator fills from the top so it
// holds the complete result after the last chunk.
module seq_adder #(
  parameter int W     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] z,
  output logic         cout,
  output logic [31:0]  op_count
);

  localparam int N  = W / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_acc;
  logic [IW-1:0]  r_idx;
  logic           r_carry;

  logic [CHUNK:0] w_sum;
  logic [W-1:0]   w_accNext;
  logic           w_lastChunk;

  // Sum of the current (bottom) chunk of both operands plus the running carry.
  assign w_sum = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};

  // New chunk sum enters at the top; after N cycles chunk 0 has reached bit 0.
  assign w_accNext = (r_acc >> CHUNK) | (W'(w_sum[CHUNK-1:0]) << (W - CHUNK));

  assign w_lastChunk = (r_idx == IW'(N - 1));

  assign busy = (r_state == CALC);
  assign done = (r_state == DONE);

  // Control FSM and datapath: accept in IDLE/DONE, add one chunk per CALC
  // cycle, and publish z/cout/op_count only on the edge entering DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      z        <= '0;
      cout     <= 1'b0;
      op_count <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_state <= CALC;
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_acc   <= w_accNext;
          r_carry <= w_sum[CHUNK];
          if (w_lastChunk) begin
            r_idx    <= '0;
            z        <= w_accNext;
            cout     <= w_sum[CHUNK];
            op_count <= op_count + 32'd1;
            r_state  <= DONE;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_adder.sv
// tb_seq_adder: drives seq_adder (W=32, CHUNK=8) through reset, single
// operations, carry boundaries, ignored mid-calculation requests, back-to-back
// streaming and reset abort, comparing against plain 33-bit addition.
module tb_seq_adder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] z;
  logic        cout;
  logic [31:0] op_count;

  int checks   = 0;
  int errors   = 0;
  int expCount = 0;

  seq_adder #(.W(32), .CHUNK(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .z        (z),
    .cout     (cout),
    .op_count (op_count)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // busy and done must never be high together while out of reset.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      checks++;
      if ((busy & done) !== 1'b0) begin
        errors++;
        $display("[TB] FAIL busy_done_exclusive busy=%b done=%b required not both high", busy, done);
      end
    end
  end

  // Hard stop in case something hangs outside the bounded loops.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog simulation time exceeded");
    $fatal(1, "[TB] watchdog");
  end

  // Reference: the full sum with carry as plain 33-bit arithmetic.
  function automatic logic [32:0] refAdd(input logic [31:0] x, input logic [31:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  // Presents one request (call with clk low), scrambles a/b after the
  // accepting edge, then waits a bounded time for done. lat is the number of
  // falling edges after acceptance until done is seen (0 on timeout).
  task automatic applyStimulus(input logic [31:0] ia, input logic [31:0] ib,
                               output logic [31:0] zObs, output logic cObs,
                               output int busyCnt, output int lat,
                               output logic doneAfter);
    start = 1'b1;
    a = ia;
    b = ib;
    @(negedge clk);
    start = 1'b0;
    busyCnt = 0;
    lat = 0;
    zObs = 'x;
    cObs = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) @(negedge clk);
      if (busy === 1'b1) busyCnt++;
      a = $urandom;
      b = $urandom;
      if (done === 1'b1) begin
        lat = i;
        zObs = z;
        cObs = cout;
        break;
      end
    end
    @(negedge clk);
    doneAfter = done;
  endtask

  // Outputs go to zero as soon as reset asserts, before any clock edge.
  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #3;
    checks++;
    if ({busy, done, z, cout, op_count} !== 66'd0) begin
      errors++;
      $display("[TB] FAIL reset_state busy=%b done=%b z=%h cout=%b op_count=%0d required all zero",
               busy, done, z, cout, op_count);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    expCount = 0;
  endtask

  // 3 + 4: four busy cycles, single done pulse, latency N+1 falling edges.
  task automatic test_basic();
    logic [31:0] zObs;
    logic cObs, doneAfter;
    int busyCnt, lat;
    applyStimulus(32'h3, 32'h4, zObs, cObs, busyCnt, lat, doneAfter);
    expCount++;
    checks++;
    if (zObs !== 32'h7) begin errors++; $display("[TB] FAIL basic_z got=%h exp=%h", zObs, 32'h7); end
    checks++;
    if (cObs !== 1'b0) begin errors++; $display("[TB] FAIL basic_cout got=%b exp=0", cObs); end
    checks++;
    if (busyCnt != 4) begin errors++; $display("[TB] FAIL basic_busy_cycles got=%0d exp=4", busyCnt); end
    checks++;
    if (lat != 5) begin errors++; $display("[TB] FAIL basic_latency got=%0d exp=5", lat); end
    checks++;
    if (doneAfter !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_width got=%b exp=0", doneAfter); end
    checks++;
    if (op_count !== 32'(expCount)) begin
      errors++; $display("[TB] FAIL basic_op_count got=%0d exp=%0d", op_count, expCount);
    end
    checks++;
    if (z !== 32'h7) begin errors++; $display("[TB] FAIL basic_z_hold got=%h exp=%h", z, 32'h7); end
  endtask

  // Carry rippling across all chunks, and a carry into chunk 1 only.
  task automatic test_carry();
    logic [31:0] zObs;
    logic cObs, doneAfter;
    int busyCnt, lat;
    applyStimulus(32'hFFFF_FFFF, 32'h1, zObs, cObs, busyCnt, lat, doneAfter);
    expCount++;
    checks++;
    if ({cObs, zObs} !== 33'h1_0000_0000) begin
      errors++; $display("[TB] FAIL carry_full got cout=%b z=%h exp cout=1 z=00000000", cObs, zObs);
    end
    applyStimulus(32'h0000_00FF, 32'h1, zObs, cObs, busyCnt, lat, doneAfter);
    expCount++;
    checks++;
    if ({cObs, zObs} !== 33'h0_0000_0100) begin
      errors++; $display("[TB] FAIL carry_chunk got cout=%b z=%h exp cout=0 z=00000100", cObs, zObs);
    end
    checks++;
    if (op_count !== 32'(expCount)) begin
      errors++; $display("[TB] FAIL carry_op_count got=%0d exp=%0d", op_count, expCount);
    end
  endtask

  // Random single operations against the reference sum.
  task automatic test_random();
    logic [31:0] zObs, ra, rb;
    logic cObs, doneAfter;
    logic [32:0] exp;
    int busyCnt, lat;
    for (int k = 0; k < 6; k++) begin
      ra = $urandom;
      rb = $urandom;
      exp = refAdd(ra, rb);
      applyStimulus(ra, rb, zObs, cObs, busyCnt, lat, doneAfter);
      expCount++;
      checks++;
      if ({cObs, zObs} !== exp) begin
        errors++; $display("[TB] FAIL random_sum a=%h b=%h got=%h exp=%h", ra, rb, {cObs, zObs}, exp);
      end
      checks++;
      if (lat != 5) begin errors++; $display("[TB] FAIL random_latency got=%0d exp=5", lat); end
    end
  endtask

  // A start pulse during CALC is ignored and operand changes don't leak in.
  task automatic test_ignore_start();
    int dones = 0;
    int doneAt = 0;
    logic [31:0] zSeen = 'x;
    start = 1'b1;
    a = 32'h1234_5678;
    b = 32'h1111_1111;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dones++;
        zSeen = z;
        doneAt = i;
      end
      start = (i == 2);
      a = (i == 2) ? 32'h0 : $urandom;
      b = (i == 2) ? 32'h0 : $urandom;
    end
    start = 1'b0;
    expCount++;
    checks++;
    if (dones != 1) begin errors++; $display("[TB] FAIL ignore_done_count got=%0d exp=1", dones); end
    checks++;
    if (zSeen !== 32'h2345_6789) begin errors++; $display("[TB] FAIL ignore_z got=%h exp=23456789", zSeen); end
    checks++;
    if (doneAt != 5) begin errors++; $display("[TB] FAIL ignore_latency got=%0d exp=5", doneAt); end
    checks++;
    if (op_count !== 32'(expCount)) begin
      errors++; $display("[TB] FAIL ignore_op_count got=%0d exp=%0d", op_count, expCount);
    end
  endtask

  // start held high: a new pair is accepted from every DONE cycle.
  task automatic test_back_to_back();
    logic [31:0] pa [16];
    logic [31:0] pb [16];
    logic [32:0] exp;
    int k = 0;
    for (int i = 0; i < 16; i++) begin
      pa[i] = $urandom;
      pb[i] = $urandom;
    end
    start = 1'b1;
    a = pa[0];
    b = pb[0];
    for (int i = 1; i <= 100 && k < 16; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        exp = refAdd(pa[k], pb[k]);
        checks++;
        if ({cout, z} !== exp) begin
          errors++; $display("[TB] FAIL b2b_sum idx=%0d got=%h exp=%h", k, {cout, z}, exp);
        end
        checks++;
        if (i != 5 * (k + 1)) begin
          errors++; $display("[TB] FAIL b2b_spacing idx=%0d got_cycle=%0d exp_cycle=%0d", k, i, 5 * (k + 1));
        end
        expCount++;
        k++;
        if (k < 16) begin
          a = pa[k];
          b = pb[k];
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (k != 16) begin errors++; $display("[TB] FAIL b2b_completed got=%0d exp=16", k); end
    checks++;
    if (op_count !== 32'(expCount)) begin
      errors++; $display("[TB] FAIL b2b_op_count got=%0d exp=%0d", op_count, expCount);
    end
  endtask

  // Reset mid-CALC abandons the operation; the first edge after release accepts.
  task automatic test_reset_mid_calc();
    logic [31:0] zObs;
    logic cObs, doneAfter;
    int busyCnt, lat;
    int dones = 0;
    start = 1'b1;
    a = $urandom;
    b = $urandom;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midreset_busy_before got=%b exp=1", busy); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, z, cout, op_count} !== 66'd0) begin
      errors++;
      $display("[TB] FAIL midreset_async busy=%b done=%b z=%h cout=%b op_count=%0d required all zero",
               busy, done, z, cout, op_count);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done !== 1'b0) dones++;
    end
    checks++;
    if (dones != 0) begin errors++; $display("[TB] FAIL midreset_no_done got=%0d exp=0", dones); end
    expCount = 0;
    reset_n = 1'b1;
    applyStimulus(32'h8000_0000, 32'h8000_0000, zObs, cObs, busyCnt, lat, doneAfter);
    expCount++;
    checks++;
    if ({cObs, zObs} !== 33'h1_0000_0000) begin
      errors++; $display("[TB] FAIL midreset_sum got cout=%b z=%h exp cout=1 z=00000000", cObs, zObs);
    end
    checks++;
    if (lat != 5) begin errors++; $display("[TB] FAIL midreset_latency got=%0d exp=5", lat); end
    checks++;
    if (op_count !== 32'(expCount)) begin
      errors++; $display("[TB] FAIL midreset_op_count got=%0d exp=%0d", op_count, expCount);
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_calc();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
